// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               pend;
  logic               pend_dbz;

  logic               op_mul;
  logic               op_div;
  logic               op_sgn;
  logic               op_mthi;
  logic               op_mtlo;
  logic               rt_zero;
  logic               go_run;
  logic               go_dbz;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  always_comb begin
    op_mul  = (op[2:1] == 2'b00);
    op_div  = (op[2:1] == 2'b01);
    op_sgn  = ~op[0];
    op_mthi = (op == 3'b100);
    op_mtlo = (op == 3'b101);
    rt_zero = (rt == '0);
    go_run  = op_mul | (op_div & ~rt_zero);
    go_dbz  = op_div & rt_zero;
    a_neg   = (op_mul | op_div) & op_sgn & rs[WIDTH-1];
    b_neg   = (op_mul | op_div) & op_sgn & rt[WIDTH-1];
    a_mag   = a_neg ? -rs : rs;
    b_mag   = b_neg ? -rt : rt;
  end

  // acc[2W:W] is the partial product / remainder, acc[W-1:0] the
  // multiplier being consumed / quotient being built.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     r_diff;
  logic               r_ge;
  logic [2*WIDTH:0]   div_next;

  always_comb begin
    mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, opb};
    mul_next = acc[0] ? ({mul_sum, acc[WIDTH-1:0]} >> 1) : (acc >> 1);
    r_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    r_diff   = r_sh - {1'b0, opb};
    r_ge     = (r_sh >= {1'b0, opb});
    div_next = {(r_ge ? r_diff : r_sh), acc[WIDTH-2:0], r_ge};
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  always_comb begin
    prod_s = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_s  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_s  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      opb         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      pend        <= 1'b0;
      pend_dbz    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else if (clk_enable) begin
      done        <= pend;
      div_by_zero <= pend_dbz;
      pend        <= 1'b0;
      pend_dbz    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              go_run: begin
                state  <= RUN;
                busy   <= 1'b1;
                count  <= '0;
                is_div <= op_div;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                opb    <= op_div ? b_mag : a_mag;
                acc    <= {{(WIDTH+1){1'b0}}, (op_div ? a_mag : b_mag)};
              end
              go_dbz: begin
                pend     <= 1'b1;
                pend_dbz <= 1'b1;
              end
              op_mthi: begin
                hi   <= rs;
                pend <= 1'b1;
              end
              op_mtlo: begin
                lo   <= rs;
                pend <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_s;
            lo <= quo_s;
          end else begin
            {hi, lo} <= prod_s;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (WIDTH=32).
// Linear sequence of steps; every expected value is hand-computed.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  int n;
  int nb;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge just after the sampling edge E0.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs = a;
    rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n = edges after E0 until done is seen; nb = busy-high samples.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #12;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_dbz", 64'(div_by_zero), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    issue(3'b000, 32'hFFFF_FFFF, 32'h2);
    wait_done(n, nb);
    chk("mult_lat", 64'(n), 64'd33);
    chk("mult_busy", 64'(nb), 64'd33);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFFE);
    chk("mult_dbz", 64'(div_by_zero), 64'h0);
    @(negedge clk);
    chk("mult_pulse", 64'(done), 64'h0);

    issue(3'b001, 32'hFFFF_FFFF, 32'h2);
    wait_done(n, nb);
    chk("multu_lat", 64'(n), 64'd33);
    chk("multu_hi", 64'(hi), 64'h1);
    chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    issue(3'b011, 32'd100, 32'd7);
    wait_done(n, nb);
    chk("divu_lat", 64'(n), 64'd33);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);

    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, nb);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, nb);
    chk("divov_lo", 64'(lo), 64'h8000_0000);
    chk("divov_hi", 64'(hi), 64'h0);
    chk("divov_dbz", 64'(div_by_zero), 64'h0);

    issue(3'b100, 32'h11, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h11);
    chk("mthi_early", 64'(done), 64'h0);
    @(negedge clk);
    chk("mthi_done", 64'(done), 64'h1);
    chk("mthi_busy", 64'(busy), 64'h0);

    issue(3'b101, 32'h22, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'h22);
    @(negedge clk);
    chk("mtlo_done", 64'(done), 64'h1);

    issue(3'b010, 32'd5, 32'd0);
    chk("dbz_early", 64'(done), 64'h0);
    chk("dbz_busy0", 64'(busy), 64'h0);
    @(negedge clk);
    chk("dbz_done", 64'(done), 64'h1);
    chk("dbz_flag", 64'(div_by_zero), 64'h1);
    chk("dbz_busy1", 64'(busy), 64'h0);
    chk("dbz_hi", 64'(hi), 64'h11);
    chk("dbz_lo", 64'(lo), 64'h22);
    @(negedge clk);
    chk("dbz_done_off", 64'(done), 64'h0);
    chk("dbz_flag_off", 64'(div_by_zero), 64'h0);

    issue(3'b001, 32'd3, 32'd5);
    n = 0;
    repeat (5) @(negedge clk);
    n += 5;
    start = 1'b1;
    op = 3'b101;
    rs = 32'hDEAD;
    @(negedge clk);
    n++;
    start = 1'b0;
    chk("ign_busy", 64'(busy), 64'h1);
    chk("ign_lo", 64'(lo), 64'h22);
    clk_enable = 1'b0;
    repeat (4) @(negedge clk);
    n += 4;
    clk_enable = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ena_lat", 64'(n), 64'd37);
    chk("ena_lo", 64'(lo), 64'd15);
    chk("ena_hi", 64'(hi), 64'h0);
    clk_enable = 1'b0;
    @(negedge clk);
    chk("done_stretch", 64'(done), 64'h1);
    clk_enable = 1'b1;
    @(negedge clk);
    chk("done_release", 64'(done), 64'h0);

    issue(3'b110, 32'h99, 32'h0);
    @(negedge clk);
    chk("nop_done", 64'(done), 64'h0);
    chk("nop_lo", 64'(lo), 64'd15);

    issue(3'b000, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    chk("abort_busy", 64'(busy), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_lo", 64'(lo), 64'h0);
    chk("abort_busy0", 64'(busy), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_nowr", 64'(lo), 64'h0);
    chk("abort_nodone", 64'(done), 64'h0);

    issue(3'b101, 32'hABCD, 32'h0);
    chk("post_lo", 64'(lo), 64'hABCD);
    @(negedge clk);
    chk("post_done", 64'(done), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
